// File: rtl/m_shiftreg_piso_tx_pkg.sv
// State encoding shared by the PISO transmitter and anything that decodes its state.
// No logic, no latency.
// No flow control.
package m_shiftreg_piso_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/m_shiftreg_piso_tx_bit_timer.sv
// Bit-period divider: counts CLKS_PER_BIT clocks per serial bit.
// bit_tick is decoded combinationally from the counter flop (no added latency).
// No backpressure; restart holds/clears the count.
//
// Ports:
//   clk, nreset : clock, async active-low reset
//   restart     : clear the divider to the start of a bit period
//   bit_tick    : high in the last cycle of each bit period
module m_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic nreset,
    input  logic restart,
    output logic bit_tick
);

    localparam int               DIV_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    // With CLKS_PER_BIT == 1 the counter sits at 0 and ticks every cycle.
    assign bit_tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (restart || bit_tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/m_shiftreg_piso_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word, shifts it out one bit per bit period.
// First bit on d_out the cycle after the accepting edge; WIDTH*CLKS_PER_BIT cycles per word.
// load_ready only in IDLE or the final cycle of a word, so back-to-back words stream with no gap.
//
// Ports:
//   clk, nreset                      : clock, async active-low reset
//   load_data, load_valid, load_ready: parallel word load handshake
//   d_out, d_valid, busy             : serial data, bit qualifier, word-in-flight (== d_valid)
//   done                             : pulse on the final cycle of each word's last bit
module m_shiftreg_piso_tx
    import m_shiftreg_piso_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    localparam int               BIT_W    = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] shift_q,   shift_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             d_out_q,   d_out_d;

    logic bit_tick;
    logic timer_restart;
    logic last_cycle;

    m_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .nreset  (nreset),
        .restart (timer_restart),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        load_ready    = 1'b0;
        done          = 1'b0;
        last_cycle    = 1'b0;
        timer_restart = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_ready    = 1'b1;
                // Hold the divider at the start of a period so the first bit gets a full period.
                timer_restart = 1'b1;
                if (load_valid) begin
                    shift_d   = load_data;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                last_cycle = bit_tick && (bit_cnt_q == BIT_LAST);
                done       = last_cycle;
                load_ready = last_cycle;
                if (last_cycle && load_valid) begin
                    // Reload in place: next word's first bit follows with no idle cycle.
                    timer_restart = 1'b1;
                    shift_d       = load_data;
                    bit_cnt_d     = '0;
                end else if (last_cycle) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else if (bit_tick) begin
                    shift_d   = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, shift_q[WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // d_out is a flop fed with the bit the next cycle will present.
        if (state_d == ST_SHIFT) begin
            d_out_d = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
        end else begin
            d_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            d_out_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            d_out_q   <= d_out_d;
        end
    end

    assign d_out   = d_out_q;
    assign d_valid = (state_q == ST_SHIFT);
    assign busy    = d_valid;

endmodule

// File: tb/tb_m_shiftreg_piso_tx.sv
// Bench for m_shiftreg_piso_tx: two instances (8/1/MSB-first and 8/3/LSB-first),
// a word-level timing model checked every cycle, literal trace checks and a serial loopback.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
module tb_m_shiftreg_piso_tx;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   nreset     = 2'b00;
    logic [1:0]   load_valid = 2'b00;
    logic [W-1:0] load_data [2];
    logic [1:0]   load_ready, d_out, d_valid, busy, done;

    m_shiftreg_piso_tx #(.WIDTH(W), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .nreset(nreset[0]), .load_data(load_data[0]), .load_valid(load_valid[0]),
        .load_ready(load_ready[0]), .d_out(d_out[0]), .d_valid(d_valid[0]), .busy(busy[0]),
        .done(done[0]));

    m_shiftreg_piso_tx #(.WIDTH(W), .CLKS_PER_BIT(3), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .nreset(nreset[1]), .load_data(load_data[1]), .load_valid(load_valid[1]),
        .load_ready(load_ready[1]), .d_out(d_out[1]), .d_valid(d_valid[1]), .busy(busy[1]),
        .done(done[1]));

    int cpb  [2] = '{1, 3};
    bit msbf [2] = '{1'b1, 1'b0};

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: dut=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- word-level model ----------------
    // m_e = cycle number (1..W*cpb) within the word in flight, 0 when idle.
    int           m_e    [2];
    logic [W-1:0] m_word [2];
    logic [1:0]   m_acc  = 2'b00;
    logic         e_do, e_dv, e_dn, e_rd;
    int           k;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!nreset[i]) m_e[i] = 0;
            if (m_e[i] == 0) begin
                e_do = 1'b0; e_dv = 1'b0; e_dn = 1'b0; e_rd = 1'b1;
            end else begin
                k    = (m_e[i] - 1) / cpb[i];
                e_dv = 1'b1;
                e_do = msbf[i] ? m_word[i][W-1-k] : m_word[i][k];
                e_dn = (m_e[i] == W * cpb[i]);
                e_rd = e_dn;
            end
            check($sformatf("u%0d.d_out@%0t", i, $time),      d_out[i],      e_do);
            check($sformatf("u%0d.d_valid@%0t", i, $time),    d_valid[i],    e_dv);
            check($sformatf("u%0d.busy@%0t", i, $time),       busy[i],       e_dv);
            check($sformatf("u%0d.done@%0t", i, $time),       done[i],       e_dn);
            check($sformatf("u%0d.load_ready@%0t", i, $time), load_ready[i], e_rd);
            m_acc[i] = nreset[i] && load_valid[i] && e_rd;
            if (m_acc[i]) begin
                m_word[i] = load_data[i];
                m_e[i]    = 1;
            end else if (m_e[i] != 0 && !e_dn) begin
                m_e[i]++;
            end else begin
                m_e[i] = 0;
            end
        end
    end

    // ---------------- serial-in receiver for loopback ----------------
    logic [1:0]   lb_on = 2'b00;
    logic [W-1:0] sent_q [$];
    logic [W-1:0] rx_w [2];
    int           rx_c [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!lb_on[i] || !nreset[i]) begin
                rx_c[i] = 0;
            end else if (d_valid[i]) begin
                rx_c[i]++;
                if (rx_c[i] % cpb[i] == 0)
                    rx_w[i] = msbf[i] ? {rx_w[i][W-2:0], d_out[i]} : {d_out[i], rx_w[i][W-1:1]};
                if (rx_c[i] == W * cpb[i]) begin
                    rx_c[i] = 0;
                    if (sent_q.size() == 0) check($sformatf("u%0d.rx_unexpected", i), rx_w[i], 64'hDEAD);
                    else check($sformatf("u%0d.rx_word", i), rx_w[i], sent_q.pop_front());
                end
            end
        end
    end

    // ---------------- trace capture for literal checks ----------------
    logic [63:0] cap_so, cap_dv, cap_dn, cap_rd;

    task automatic cap_clear();
        cap_so = '0; cap_dv = '0; cap_dn = '0; cap_rd = '0;
    endtask

    // Drive inputs for one cycle, record outputs at negedge, end at posedge+1.
    task automatic cycle_cap(input int i, input logic v, input logic [W-1:0] d);
        load_valid[i] = v;
        load_data[i]  = d;
        @(negedge clk);
        cap_so = {cap_so[62:0], d_out[i]};
        cap_dv = {cap_dv[62:0], d_valid[i]};
        cap_dn = {cap_dn[62:0], done[i]};
        cap_rd = {cap_rd[62:0], load_ready[i]};
        @(posedge clk);
        #1;
    endtask

    task automatic loopback(input int i);
        int           t;
        int           gap;
        logic [W-1:0] w;
        sent_q.delete();
        lb_on[i] = 1'b1;
        for (int n = 0; n < 256; n++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                load_valid[i] = 1'b0;
                load_data[i]  = W'($urandom);
                @(posedge clk);
                #1;
            end
            w             = W'($urandom);
            load_valid[i] = 1'b1;
            load_data[i]  = w;
            t             = 0;
            do begin
                @(posedge clk);
                #1;
                t++;
            end while (!m_acc[i] && t < 64);
            if (!m_acc[i]) begin
                check($sformatf("u%0d.lb_accept_timeout", i), 0, 1);
                break;
            end
            sent_q.push_back(w);
        end
        load_valid[i] = 1'b0;
        repeat (W * cpb[i] + 4) @(posedge clk);
        #1;
        check($sformatf("u%0d.lb_words_left", i), sent_q.size(), 0);
        lb_on[i] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        load_data[0] = '0;
        load_data[1] = '0;
        cap_clear();
        repeat (2) @(posedge clk);
        #1;
        // reset state
        check("rst.d_out",      d_out,      2'b00);
        check("rst.d_valid",    d_valid,    2'b00);
        check("rst.busy",       busy,       2'b00);
        check("rst.done",       done,       2'b00);
        check("rst.load_ready", load_ready, 2'b11);
        nreset = 2'b11;
        @(posedge clk);
        #1;

        // single word A5, MSB first, 1 clk/bit
        cycle_cap(0, 1'b1, 8'hA5);
        cap_clear();
        for (int c = 1; c <= 9; c++) cycle_cap(0, 1'b0, 8'h00);
        check("t1.serial", cap_so, {8'hA5, 1'b0});
        check("t1.d_valid", cap_dv, 9'b111111110);
        check("t1.done", cap_dn, 9'b000000010);
        check("t1.load_ready", cap_rd, 9'b000000011);

        // back-to-back A5, 3C with load_valid held
        cycle_cap(0, 1'b1, 8'hA5);
        cap_clear();
        for (int c = 1; c <= 17; c++) cycle_cap(0, c <= 8, 8'h3C);
        check("t2.serial", cap_so, {8'hA5, 8'h3C, 1'b0});
        check("t2.d_valid", cap_dv, {16'hFFFF, 1'b0});
        check("t2.done", cap_dn, {7'b0, 1'b1, 7'b0, 1'b1, 1'b0});

        // LSB first, 3 clk/bit, zero fill
        cycle_cap(1, 1'b1, 8'h01);
        cap_clear();
        for (int c = 1; c <= 25; c++) cycle_cap(1, 1'b0, 8'h00);
        check("t3.serial", cap_so, {3'b111, 22'b0});
        check("t3.d_valid", cap_dv, {24'hFFFFFF, 1'b0});
        check("t3.done", cap_dn, 25'b10);

        // async reset during bit 4 of FF
        cycle_cap(0, 1'b1, 8'hFF);
        for (int c = 1; c <= 4; c++) cycle_cap(0, 1'b0, 8'h00);
        #1;
        check("t4.pre_d_valid", d_valid[0], 1'b1);
        nreset[0] = 1'b0;
        #1;
        check("t4.d_out", d_out[0], 1'b0);
        check("t4.d_valid", d_valid[0], 1'b0);
        check("t4.busy", busy[0], 1'b0);
        check("t4.done", done[0], 1'b0);
        check("t4.load_ready", load_ready[0], 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        nreset[0] = 1'b1;
        cycle_cap(0, 1'b0, 8'h00);
        cycle_cap(0, 1'b1, 8'h81);
        cap_clear();
        for (int c = 1; c <= 9; c++) cycle_cap(0, 1'b0, 8'h00);
        check("t4.serial", cap_so, {8'h81, 1'b0});
        check("t4.done", cap_dn, 9'b000000010);

        // load_valid/load_data toggling mid-word is ignored
        cycle_cap(0, 1'b1, 8'hC3);
        cap_clear();
        for (int c = 1; c <= 17; c++) begin
            if (c <= 7)      cycle_cap(0, c % 2 == 1, (c % 2 == 1) ? 8'hFF : 8'h00);
            else if (c == 8) cycle_cap(0, 1'b1, 8'h96);
            else             cycle_cap(0, 1'b0, 8'hFF);
        end
        check("t5.serial", cap_so, {8'hC3, 8'h96, 1'b0});
        check("t5.done", cap_dn, {7'b0, 1'b1, 7'b0, 1'b1, 1'b0});

        // random loopback on both configurations
        loopback(0);
        loopback(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m_shiftreg_piso_tx.md
Name: m_shiftreg_piso_tx

Overview:
Parallel-in, serial-out shift-register transmitter. It is the transmit counterpart of the team's serial-in capture registers.
- Accepts a WIDTH-bit word over a valid/ready load handshake.
- Shifts the word out one bit per bit period on a single serial line, with a data-valid qualifier.
- Supports back-to-back words with no idle gap, so a downstream serial-in register sees a continuous stream.

Parameters:
WIDTH, 8, word length in bits; legal range >= 2.
CLKS_PER_BIT, 1, clock cycles each bit is held on d_out; legal range >= 1.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
clk  input  1  system clock; all state updates on posedge.
nreset  input  1  asynchronous, active-low reset.
load_data  input  WIDTH  parallel word to transmit.
load_valid  input  1  load_data is valid.
load_ready  output  1  block will accept a word on this edge if load_valid=1.
d_out  output  1  serial data out, registered.
d_valid  output  1  d_out carries a word bit.
busy  output  1  a word is in flight (equal to d_valid).
done  output  1  one-cycle pulse on the final cycle of a word's last bit.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, nreset.
- Reset (async assert, sync release): state=IDLE, shift reg=0, bit_cnt=0, div_cnt=0. Outputs: d_out=0, d_valid=0, busy=0, done=0, load_ready=1.
- States: IDLE, SHIFT.
- Handshake: a word is accepted on a posedge where load_valid && load_ready. load_ready is decoded from registers only and never depends on load_valid.
- IDLE:
  - load_ready=1, d_out=0, d_valid=0.
  - On accept: shift reg <= load_data, bit_cnt<=0, div_cnt<=0, state<=SHIFT.
- Latency: the first bit appears on d_out with d_valid=1 in the cycle after the accept edge.
- SHIFT:
  - d_out = shift reg MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0).
  - div_cnt counts 0..CLKS_PER_BIT-1. At wrap, the register shifts by one (zero fill) and bit_cnt increments.
- Last cycle of word: bit_cnt==WIDTH-1 && div_cnt==CLKS_PER_BIT-1. In this cycle done=1 and load_ready=1.
  - If accept occurs on this edge: reload and stay in SHIFT. The new first bit follows with no gap, d_valid stays 1, and counters reset to 0.
  - Otherwise: state<=IDLE, d_out<=0, d_valid<=0.
- load_valid in any other SHIFT cycle is ignored. load_ready=0 and load_data changes have no effect.
- Total cycles per word = WIDTH*CLKS_PER_BIT; exactly one done pulse per completed word.
- Counter widths:
  - bit_cnt is $clog2(WIDTH) bits.
  - div_cnt is max(1, $clog2(CLKS_PER_BIT)) bits.
  - CLKS_PER_BIT=1 means div_cnt wraps every cycle.
- Reset mid-word: outputs go to reset values immediately. The partial word is discarded and no done pulse is issued. The next accepted word transmits from bit 0.

Decomposition:
- Shared package/include: state encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1. Nothing else is shared.
- One natural sub-module: m_bit_timer, the CLKS_PER_BIT divider.
  - Inputs: clk, nreset, restart.
  - Output: bit_tick, high in the last cycle of each bit period.
- Shift register, bit counter and FSM stay in the top module.

Test Plan:
1. WIDTH=8, CLKS_PER_BIT=1, MSB_FIRST=1; load 8'hA5 once -> d_out 1,0,1,0,0,1,0,1 on cycles 1-8 after accept. d_valid high cycles 1-8. load_ready low cycles 1-7, high cycle 8. done only on cycle 8. Idle (d_out=0, d_valid=0) from cycle 9.
2. Back-to-back: 8'hA5, then 8'h3C with load_valid held high -> 16 contiguous d_valid cycles with serial 10100101 00111100. done on cycles 8 and 16 only.
3. MSB_FIRST=0, CLKS_PER_BIT=3; load 8'h01 -> d_out=1 for cycles 1-3, then 0 for cycles 4-24. done on cycle 24 only. Zero-fill verified.
4. Pull nreset low asynchronously mid-cycle during bit 4 of 8'hFF -> outputs reset immediately with no clock edge needed. No done pulse. After release, loading 8'h81 produces 10000001 cleanly.
5. Toggle load_valid and load_data (8'h00/8'hFF) every cycle during bits 0-6 of a word -> no effect on d_out. Only the value present on the last-cycle accept edge is transmitted next.
6. Loopback: drive d_out/d_valid into a bench serial-in shift model; 256 random words with random load_valid gaps -> every captured word equals the sent word.
